// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, entry width and default sizing for the SPI receiver
package spi_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int ENTRY_W         = 9;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: power-of-two FIFO that accepts a push while full when a pop frees a slot in the same cycle
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;
    assign empty = r_count == '0;
    assign full  = r_count == CW'(DEPTH);
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign rdata = empty ? '0 : r_mem[r_rptr];
    assign count = r_count;
    // pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end
    // storage needs no reset: rdata is masked while empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wdata;
    end
endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI slave receiver that queues {dc, byte} entries for a CPU and flags overflow and framing errors
module spi_rx
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          spi_sck,
    input  logic                          spi_cs_,
    input  logic                          spi_sdi,
    input  logic                          spi_dc,
    input  logic                          rd,
    input  logic                          clr,
    output logic [ENTRY_W-1:0]            rdata,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ovf,
    output logic                          ferr,
    output logic                          busy
);
    logic [3:0]         r_sync [SYNC_STAGES];
    logic               r_sck_d;
    state_t             r_state;
    logic [6:0]         r_shift;
    logic [2:0]         r_bitcnt;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_push;
    logic               r_ovf;
    logic               r_ferr;
    logic               w_sck;
    logic               w_cs;
    logic               w_sdi;
    logic               w_dc;
    logic               w_rise;
    logic               w_drop;
    logic               w_ferr_set;
    assign w_sck      = r_sync[SYNC_STAGES-1][3];
    assign w_cs       = r_sync[SYNC_STAGES-1][2];
    assign w_sdi      = r_sync[SYNC_STAGES-1][1];
    assign w_dc       = r_sync[SYNC_STAGES-1][0];
    assign w_rise     = w_sck & ~r_sck_d;
    assign w_ferr_set = (r_state == SHIFT) & w_cs & (r_bitcnt != 3'd0);
    assign busy       = r_state == SHIFT;
    assign ovf        = r_ovf;
    assign ferr       = r_ferr;
    // synchronise {sck, cs_, sdi, dc}; idle values keep a reset from looking like an edge or a frame
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b1100;
            r_sck_d <= 1'b1;
        end else begin
            r_sync[0] <= {spi_sck, spi_cs_, spi_sdi, spi_dc};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_sck_d <= w_sck;
        end
    end
    // frame FSM: shift on sck rises, latch and push a completed byte, stay in SHIFT until cs_ rises
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_entry  <= '0;
            r_push   <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (r_state == IDLE) begin
                if (!w_cs) begin
                    r_state  <= SHIFT;
                    r_shift  <= '0;
                    r_bitcnt <= '0;
                end
            end else if (w_cs) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
            end else if (w_rise) begin
                r_shift  <= {r_shift[5:0], w_sdi};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_entry <= {w_dc, r_shift, w_sdi};
                    r_push  <= 1'b1;
                end
            end
        end
    end
    // sticky flags: a set event wins over clr in the same cycle
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovf  <= w_drop | (r_ovf & ~clr);
            r_ferr <= w_ferr_set | (r_ferr & ~clr);
        end
    end
    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .reset_ (reset_),
        .push   (r_push),
        .pop    (rd),
        .wdata  (r_entry),
        .rdata  (rdata),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .drop   (w_drop)
    );
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed SPI frames with a scoreboard queue checked by a read monitor
module tb_spi_rx;
    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       spi_sck = 1'b1;
    logic       spi_cs_ = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       spi_dc = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [8:0] rdata;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ovf;
    logic       ferr;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];

    always #8 clk = ~clk;

    spi_rx dut (
        .clk     (clk),
        .reset_  (reset_),
        .spi_sck (spi_sck),
        .spi_cs_ (spi_cs_),
        .spi_sdi (spi_sdi),
        .spi_dc  (spi_dc),
        .rd      (rd),
        .clr     (clr),
        .rdata   (rdata),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .ferr    (ferr),
        .busy    (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // each accepted pop presents the head entry, compared against the oldest expectation
    always @(negedge clk) begin
        if (reset_ && rd) begin
            if (empty) check("rd_empty_rdata", int'(rdata), 0);
            else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got 0x%0h expected none", rdata);
            end else check("pop_rdata", int'(rdata), int'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0 plain, 1 rd aligned with the push cycle, 2 check push latency on the last rise
    task automatic send_bits(input logic [7:0] b, input int n, input logic d, input int mode);
        int c0;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_sck = 1'b0;
            spi_sdi = b[i];
            spi_dc  = d;
            tick(6);
            spi_sck = 1'b1;
            if (i == 8 - n && mode != 0) begin
                c0 = int'(count);
                tick(3);
                if (mode == 2) check("latency_before", int'(count), c0);
                else rd = 1'b1;
                tick(1);
                rd = 1'b0;
                if (mode == 2) check("latency_after", int'(count), c0 + 1);
                tick(2);
            end else tick(6);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input int mode);
        exp_q.push_back({d, b});
        send_bits(b, 8, d, mode);
    endtask

    task automatic cs_low();
        spi_cs_ = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        spi_cs_ = 1'b1;
        tick(8);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            rd = 1'b1;
            tick(1);
            rd = 1'b0;
            tick(1);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v [5];
        v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tick(3);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_ferr", int'(ferr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rdata", int'(rdata), 0);
        reset_ = 1'b1;
        tick(2);

        cs_low();
        check("busy_frame", int'(busy), 1);
        send_byte(8'hA5, 1'b1, 2);
        cs_high();
        check("a5_count", int'(count), 1);
        check("a5_rdata", int'(rdata), 'h1A5);
        check("a5_ferr", int'(ferr), 0);
        check("a5_busy_idle", int'(busy), 0);
        drain(1);
        check("a5_empty", int'(empty), 1);

        cs_low();
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b1, 0);
        cs_high();
        check("two_count", int'(count), 2);
        check("two_head", int'(rdata), 'h012);
        drain(1);
        check("two_second", int'(rdata), 'h134);
        drain(1);
        check("two_empty", int'(empty), 1);

        cs_low();
        for (int i = 0; i < 5; i++) send_byte(v[i], i[0], 0);
        void'(exp_q.pop_back());
        cs_high();
        check("ovf_full", int'(full), 1);
        check("ovf_flag", int'(ovf), 1);
        check("ovf_count", int'(count), 4);
        check("ovf_head", int'(rdata), 'h011);
        pulse_clr();
        check("ovf_clr", int'(ovf), 0);
        drain(4);
        check("ovf_drained", int'(empty), 1);
        drain(1);
        check("underflow_count", int'(count), 0);

        cs_low();
        send_bits(8'hB7, 5, 1'b1, 0);
        cs_high();
        check("ferr_set", int'(ferr), 1);
        check("ferr_count", int'(count), 0);
        check("ferr_no_ovf", int'(ovf), 0);
        pulse_clr();
        check("ferr_clr", int'(ferr), 0);

        cs_low();
        send_byte(8'hC1, 1'b0, 0);
        send_byte(8'hC2, 1'b1, 0);
        send_byte(8'hC3, 1'b0, 0);
        send_byte(8'hC4, 1'b1, 0);
        send_byte(8'h99, 1'b1, 1);
        cs_high();
        check("rdpush_count", int'(count), 4);
        check("rdpush_full", int'(full), 1);
        check("rdpush_ovf", int'(ovf), 0);
        check("rdpush_head", int'(rdata), 'h1C2);
        drain(4);
        check("rdpush_empty", int'(empty), 1);

        cs_low();
        send_bits(8'hF0, 4, 1'b0, 0);
        reset_  = 1'b0;
        spi_cs_ = 1'b1;
        spi_sck = 1'b1;
        tick(3);
        check("midrst_busy", int'(busy), 0);
        reset_ = 1'b1;
        tick(4);
        exp_q.delete();
        cs_low();
        send_byte(8'h3C, 1'b1, 0);
        cs_high();
        check("midrst_rdata", int'(rdata), 'h13C);
        check("midrst_ferr", int'(ferr), 0);
        check("midrst_count", int'(count), 1);
        drain(1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of received-frame entries (power of 2, at least 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop count on each asynchronous SPI input.
REQ-003 Port clk, input, 1, system clock (62.5 MHz); one clock domain.
REQ-004 Port reset_, input, 1, asynchronous active-low reset.
REQ-005 Port spi_sck, input, 1, serial clock; idles high; sample on rising edge.
REQ-006 Port spi_cs_, input, 1, active-low frame select.
REQ-007 Port spi_sdi, input, 1, serial data, MSB first.
REQ-008 Port spi_dc, input, 1, data/command flag; 1 = data.
REQ-009 Port rd, input, 1, one-cycle pop strobe from the CPU bus.
REQ-010 Port clr, input, 1, one-cycle strobe that clears the sticky flags.
REQ-011 Port rdata, output, 9, head entry {dc, byte[7:0]}; 0 when empty.
REQ-012 Port empty, output, 1, FIFO holds no entries.
REQ-013 Port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-014 Port count, output, $clog2(FIFO_DEPTH)+1, number of stored entries.
REQ-015 Port ovf, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-016 Port ferr, output, 1, sticky flag: spi_cs_ rose mid-byte.
REQ-017 Port busy, output, 1, frame active (FSM not in IDLE).

Function
REQ-018 Synchronisation: spi_sck, spi_cs_, spi_sdi and spi_dc SHALL each pass through SYNC_STAGES flip-flops before use.
REQ-019 Rising-edge detect: a rising edge SHALL be a synchronised sck that is 1 in the current cycle and was 0 in the previous cycle.
REQ-020 Rate limit: correct operation SHALL be guaranteed for sck high and low phases of at least 4 clk cycles each; nominal sender phase is 25 cycles.
REQ-021 FSM states SHALL be IDLE and SHIFT.
REQ-022 IDLE -> SHIFT: on a synchronised spi_cs_ of 0; the bit counter SHALL be set to 0.
REQ-023 In SHIFT, each rising edge SHALL shift spi_sdi into bit 0 of the shift register and increment the 3-bit bit counter.
REQ-024 On the 8th rising edge (counter 7 -> 0 wrap), the block SHALL latch spi_dc together with the completed byte.
REQ-025 That {dc, byte} pair SHALL be pushed into the FIFO on the following clk cycle.
REQ-026 The FSM SHALL remain in SHIFT after a push, so several bytes per frame are accepted.
REQ-027 SHIFT -> IDLE when spi_cs_ rises: if the bit counter is 0, there SHALL be no side effect.
REQ-028 SHIFT -> IDLE when spi_cs_ rises: if the bit counter is not 0, the partial byte SHALL be discarded and ferr set to 1.
REQ-029 A push with the FIFO not full SHALL store the entry and increment count.
REQ-030 A push with the FIFO full and no rd in the same cycle SHALL drop the entry and set ovf to 1.
REQ-031 A push with the FIFO full and rd in the same cycle SHALL accept the entry; count stays FIFO_DEPTH.
REQ-032 rd with the FIFO not empty SHALL advance the head on the next edge; rdata updates in that same cycle.
REQ-033 rd with the FIFO empty SHALL be ignored; count SHALL NOT underflow.
REQ-034 Simultaneous push and rd with the FIFO not empty SHALL leave count unchanged.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 clr SHALL zero ovf and ferr on the next edge; a set event in the same cycle SHALL take priority.
REQ-037 Push latency SHALL be SYNC_STAGES+2 clk cycles from the 8th raw sck rise to the count increment.

Reset
REQ-038 While reset_ is 0: FSM in IDLE, shift register and bit counter 0, synchroniser flops sck=1, cs_=1, sdi=0, dc=0.
REQ-039 While reset_ is 0: pointers 0, count 0, empty=1, full=0, ovf=0, ferr=0, busy=0, rdata=0.
REQ-040 Reset mid-frame SHALL discard the partial byte without setting ferr.

Structure
REQ-041 Package spi_pkg SHALL hold the FSM state encoding, the entry width (9), and default FIFO_DEPTH and SYNC_STAGES.
REQ-042 FIFO storage SHALL be a single sub-module, spi_rx_fifo, parameterised by depth and width.

Verification
REQ-043 Frame with cs_ low, byte 0xA5, dc=1, then cs_ high -> count=1, rdata=0x1A5, ferr=0.
REQ-044 One cs_ frame carrying 0x12 (dc=0) then 0x34 (dc=1) -> rdata 0x012; after rd, 0x134; after a second rd, empty=1.
REQ-045 Five bytes with no rd, depth 4 -> full=1, ovf=1, the first four bytes retained in order.
REQ-046 cs_ high after 5 bits -> ferr=1, count unchanged; clr -> ferr=0.
REQ-047 rd asserted in the same cycle as a push while full -> count stays 4, ovf=0.
REQ-048 reset_ low after 4 bits, then a full 0x3C frame -> rdata=0x13C, ferr=0.
